// File: rtl/program_loader_if.sv
// Loader bus: byte stream in, instruction-memory write port and status out.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready handshake; the source holds in_data until accepted.
//
// Ports (slave = loader side):
//   in_valid, in_data, reload            -> into the loader
//   in_ready, im_we, im_addr, im_wdata,
//   cpu_run, busy, load_err              <- from the loader
interface program_loader_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);
   logic               in_valid;
   logic [7:0]         in_data;
   logic               in_ready;
   logic               reload;
   logic               im_we;
   logic [ADDR_W-1:0]  im_addr;
   logic [INSTR_W-1:0] im_wdata;
   logic               cpu_run;
   logic               busy;
   logic               load_err;

   modport master (
      output in_valid, in_data, reload,
      input  in_ready, im_we, im_addr, im_wdata, cpu_run, busy, load_err
   );

   modport slave (
      input  in_valid, in_data, reload,
      output in_ready, im_we, im_addr, im_wdata, cpu_run, busy, load_err
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles MSB-first 16-bit words from a byte stream, writes imem, verifies 8-bit checksum.
// Latency: 3 cycles per word (HI, LO, WRITE); DONE/ERR follows the CSUM byte by one cycle.
// Backpressure: in_ready only in LEN/HI/LO/CSUM; bytes offered in IDLE/WRITE/DONE/ERR are held by the source.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   io_bus      program_loader_if.slave (stream in, imem write port, cpu_run/busy/load_err)
module program_loader #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   program_loader_if.slave  io_bus
);

   localparam int CW = ADDR_W + 1;   // word counter must represent 2^ADDR_W

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_HI,
      S_LO,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CW-1:0]      r_idx;
   logic [CW-1:0]      r_cnt_max;
   logic [7:0]         r_sum;
   logic [INSTR_W-1:0] r_word;

   logic               w_in_ready;
   logic               w_xfer;
   logic [7:0]         w_sum_next;
   logic [CW-1:0]      w_idx_inc;

   // All outputs decode from the state register or registered datapath only.
   assign w_in_ready = (r_state == S_LEN) || (r_state == S_HI) ||
                       (r_state == S_LO)  || (r_state == S_CSUM);
   assign w_xfer     = io_bus.in_valid && w_in_ready;
   assign w_sum_next = r_sum + io_bus.in_data;
   assign w_idx_inc  = r_idx + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = S_LEN;
         S_LEN:   if (w_xfer) w_next = S_HI;
         S_HI:    if (w_xfer) w_next = S_LO;
         S_LO:    if (w_xfer) w_next = S_WRITE;
         S_WRITE: w_next = (w_idx_inc == r_cnt_max) ? S_CSUM : S_HI;
         S_CSUM:  if (w_xfer) w_next = (w_sum_next == 8'h00) ? S_DONE : S_ERR;
         S_DONE:  if (io_bus.reload) w_next = S_IDLE;
         S_ERR:   if (io_bus.reload) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx     <= '0;
         r_cnt_max <= '0;
         r_sum     <= '0;
         r_word    <= '0;
      end else begin
         case (r_state)
            S_LEN: begin
               if (w_xfer) begin
                  // A LEN byte of zero means a full 2^ADDR_W-word image.
                  r_cnt_max <= (io_bus.in_data == 8'h00) ? CW'(256) : CW'(io_bus.in_data);
                  r_idx     <= '0;
                  r_sum     <= '0;
               end
            end
            S_HI: begin
               if (w_xfer) begin
                  r_word[INSTR_W-1 -: 8] <= io_bus.in_data;
                  r_sum                  <= w_sum_next;
               end
            end
            S_LO: begin
               if (w_xfer) begin
                  r_word[7:0] <= io_bus.in_data;
                  r_sum       <= w_sum_next;
               end
            end
            S_WRITE: begin
               r_idx <= w_idx_inc;
            end
            default: begin
            end
         endcase
      end
   end

   assign io_bus.in_ready = w_in_ready;
   assign io_bus.im_we    = (r_state == S_WRITE);
   // Low ADDR_W bits only: the last word of a full image lands on the top address.
   assign io_bus.im_addr  = r_idx[ADDR_W-1:0];
   assign io_bus.im_wdata = r_word;
   assign io_bus.cpu_run  = (r_state == S_DONE);
   assign io_bus.busy     = w_in_ready || (r_state == S_WRITE);
   assign io_bus.load_err = (r_state == S_ERR);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   program_loader_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

   program_loader #(.ADDR_W(8), .INSTR_W(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          len_cyc = 0;
   int          lat;
   wr_t         exp_q[$];
   logic [7:0]  stm[$];
   logic [15:0] words[$];
   logic [15:0] cap[256];
   logic        prev_we = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Model: image bytes and expected writes come straight from the word list.
   task automatic build(input bit good);
      logic [7:0] s;
      int n;
      n = words.size();
      stm   = {};
      exp_q = {};
      s     = 8'h00;
      stm.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         stm.push_back(words[i][15:8]);
         stm.push_back(words[i][7:0]);
         s = s + words[i][15:8] + words[i][7:0];
         exp_q.push_back('{addr: 8'(i), data: words[i]});
      end
      stm.push_back(good ? 8'(8'h00 - s) : 8'(8'h01 - s));
   endtask

   // Offers stm[from..to-1]; optional random idle cycles on in_valid.
   task automatic send(input int from, input int to, input bit gaps);
      int  i;
      int  guard;
      int  limit;
      bit  acc;
      i     = from;
      guard = 0;
      limit = (to - from) * 20 + 50;
      while (i < to && guard < limit) begin
         if (gaps && $urandom_range(0, 99) < 35) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = stm[i];
         end
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         guard++;
         if (acc) begin
            if (i == 0) len_cyc = cyc;
            i++;
         end
      end
      bus.in_valid = 1'b0;
      if (i < to) chk("send_timeout", 32'(i), 32'(to));
   endtask

   // Returns cycles counted from the LEN acceptance edge (that cycle = 1) to DONE/ERR.
   task automatic wait_end(output int c);
      int k;
      k = 0;
      c = 0;
      while (k < 200) begin
         @(negedge clk);
         k++;
         if (bus.cpu_run || bus.load_err) break;
      end
      if (!(bus.cpu_run || bus.load_err)) chk("end_timeout", 32'(k), 32'(0));
      c = cyc - len_cyc + 1;
   endtask

   task automatic final_chk(input string tag, input bit ok);
      chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_cpu_run"}, 32'(bus.cpu_run), 32'(ok));
      chk({tag, "_load_err"}, 32'(bus.load_err), 32'(!ok));
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_im_we"}, 32'(bus.im_we), 32'd0);
      chk({tag, "_im_addr"}, 32'(bus.im_addr), 32'd0);
      chk({tag, "_im_wdata"}, 32'(bus.im_wdata), 32'd0);
      chk({tag, "_cpu_run"}, 32'(bus.cpu_run), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_load_err"}, 32'(bus.load_err), 32'd0);
   endtask

   // From DONE/ERR: request reload, then expect IDLE (idle outputs) and then LEN (busy).
   task automatic do_reload(input string tag);
      bus.reload = 1'b1;
      @(posedge clk);
      #1;
      bus.reload = 1'b0;
      chk({tag, "_run_dropped"}, 32'(bus.cpu_run), 32'd0);
      chk({tag, "_err_cleared"}, 32'(bus.load_err), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_busy_rises"}, 32'(bus.busy), 32'd1);
   endtask

   // Every cycle out of reset: each write must match the next expected write,
   // be a single-cycle strobe, and status outputs must be mutually consistent.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_we = 1'b0;
      end else begin
         if (bus.im_we) begin
            cap[bus.im_addr] = bus.im_wdata;
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {8'h0, bus.im_addr, bus.im_wdata}, 32'hFFFFFFFF);
            end else begin
               chk("write_addr_data", {8'h0, bus.im_addr, bus.im_wdata},
                   {8'h0, exp_q[0].addr, exp_q[0].data});
               void'(exp_q.pop_front());
            end
            chk("ready_during_write", 32'(bus.in_ready), 32'd0);
         end
         if (prev_we) chk("we_one_cycle", 32'(bus.im_we), 32'd0);
         if (bus.cpu_run)
            chk("run_status_clean", {29'h0, bus.in_ready, bus.busy, bus.load_err}, 32'd0);
         prev_we = bus.im_we;
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.reload   = 1'b0;
      for (int i = 0; i < 256; i++) cap[i] = 16'hDEAD;

      #12;
      zero_chk("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic load with in_valid held high.
      words = {16'h1234, 16'hABCD};
      build(1'b1);
      chk("model_ck_basic", 32'(stm[5]), 32'h42);
      send(0, 6, 1'b0);
      wait_end(lat);
      chk("run_latency", 32'(lat), 32'd8);
      final_chk("basic", 1'b1);
      chk("basic_word0", 32'(cap[0]), 32'h1234);
      chk("basic_word1", 32'(cap[1]), 32'hABCD);

      // Reload from DONE, then bad checksum.
      do_reload("reload_done");
      build(1'b0);
      chk("model_ck_bad", 32'(stm[5]), 32'h43);
      cap[0] = 16'h0;
      cap[1] = 16'h0;
      send(0, 6, 1'b0);
      wait_end(lat);
      final_chk("badck", 1'b0);
      chk("badck_word0", 32'(cap[0]), 32'h1234);
      chk("badck_word1", 32'(cap[1]), 32'hABCD);

      // Full 256-word image.
      do_reload("reload_err");
      words = {};
      for (int i = 0; i < 256; i++) words.push_back(16'(i * 16'h0101));
      build(1'b1);
      chk("model_len_full", 32'(stm[0]), 32'h00);
      chk("model_ck_full", 32'(stm[513]), 32'h00);
      send(0, 514, 1'b0);
      wait_end(lat);
      final_chk("full", 1'b1);
      chk("full_first", 32'(cap[0]), 32'h0000);
      chk("full_mid", 32'(cap[128]), 32'h8080);
      chk("full_last", 32'(cap[255]), 32'hFFFF);

      // Basic image with random idle cycles.
      do_reload("reload_gap");
      words = {16'h1234, 16'hABCD};
      build(1'b1);
      send(0, 6, 1'b1);
      wait_end(lat);
      final_chk("gaps", 1'b1);

      // Reset after the HI byte of word 1: only word 0 was written.
      do_reload("reload_rst");
      build(1'b1);
      void'(exp_q.pop_back());
      send(0, 4, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      zero_chk("midload_reset");
      chk("midload_writes", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      build(1'b1);
      send(0, 6, 1'b0);
      wait_end(lat);
      final_chk("after_reset", 1'b1);

      // Reload to a one-word image; a reload pulse during HI is ignored.
      do_reload("reload_second");
      words = {16'h0007};
      build(1'b1);
      chk("model_second_ck", 32'(stm[3]), 32'hF9);
      send(0, 1, 1'b0);
      bus.reload = 1'b1;
      @(posedge clk);
      #1;
      bus.reload = 1'b0;
      @(negedge clk);
      chk("hi_reload_busy", 32'(bus.busy), 32'd1);
      chk("hi_reload_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      send(1, 4, 1'b0);
      wait_end(lat);
      final_chk("second", 1'b1);
      chk("second_word0", 32'(cap[0]), 32'h0007);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
